// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits needed for a width-bit unsigned value: ceil(width * log10(2)).
  // 30103/100000 approximates log10(2); width*log10(2) is never an integer for width>0.
  function automatic int bcd_digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One digit of the double-dabble adjust: add 3 to any digit of 5 or more before shifting.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per cycle) with
// optional two's-complement input, overflow flag and leading-zero blanking.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WIDTH-1:0]              i_data,
  input  logic                          i_signed,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd,
  output logic                          o_neg,
  output logic                          o_ovf,
  output logic [DIGITS-1:0]             o_blank
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  bcd_state_t       r_state;
  bcd_state_t       w_next;
  logic [WIDTH-1:0] r_mag;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic             r_neg;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_in_neg;
  logic [WIDTH-1:0] w_in_mag;

  assign w_accept = (r_state == IDLE) && i_valid;
  assign w_in_neg = i_signed & i_data[WIDTH-1];
  // Negating the most-negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_in_mag = w_in_neg ? -i_data : i_data;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_valid)             w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_CNT)   w_next = DONE;
      DONE:    if (i_ready)             w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (r_state)
      IDLE:    o_ready = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  // Parallel add-3 on every digit, applied before each shift.
  for (genvar k = 0; k < DIGITS; k++) begin : gen_digit
    bcd_add3 u_add3 (
      .i_digit (r_bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .o_digit (w_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_neg <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_mag <= w_in_mag;
      r_bcd <= '0;
      r_neg <= w_in_neg;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_mag[WIDTH-1]};
      r_mag <= {r_mag[WIDTH-2:0], 1'b0};
      // Sticky: any bit pushed out of the top digit means the value needs more digits.
      r_ovf <= r_ovf | w_adj[BCD_W-1];
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bcd = r_bcd;
  assign o_ovf = r_ovf;
  // A negative input always has a nonzero magnitude, so the sign flag alone is the result sign.
  assign o_neg = r_neg;

  // Digit k is blank when it and every digit above it are zero; digit 0 always shows.
  assign o_blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : gen_blank
    assign o_blank[k] = ~|r_bcd[BCD_W-1:BCD_DIGIT_W*k];
  end

endmodule
